// File: rtl/fact_accel_param.sv
// Memory-mapped iterative factorial accelerator: one multiply per cycle, with
// overflow detection at any DATA_W and a selectable zero/saturate overflow result.
module fact_accel_param #(
    parameter int DATA_W   = 32,
    parameter int N_W      = 4,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              done_o,
    output logic              err_o
);
    // state | meaning
    // IDLE  | no computation since reset
    // BUSY  | multiplying acc by cnt, cnt counting down to 1
    // DONE  | RESULT holds N!, done_o high
    // ERR   | multiply overflowed, RESULT holds the policy value, err_o high
    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    state_t              state;
    logic [N_W-1:0]      n_reg;
    logic [N_W-1:0]      cnt;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   result;
    logic [2*DATA_W-1:0] prod;
    logic                go;
    logic                busy;
    logic                unused_wd;

    assign go        = we && (a == 2'd1) && wd[0];
    assign busy      = (state == BUSY);
    assign prod      = {{DATA_W{1'b0}}, acc} * {{(2*DATA_W-N_W){1'b0}}, cnt};
    assign unused_wd = ^wd[DATA_W-1:N_W];

    // cnt is the latched operand: it is loaded from n_reg on GO, so later
    // writes to n_reg cannot disturb a running computation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            n_reg  <= '0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            if (we && (a == 2'd0))
                n_reg <= wd[N_W-1:0];

            case (state)
                IDLE, DONE, ERR: begin
                    if (go) begin
                        acc    <= {{(DATA_W-1){1'b0}}, 1'b1};
                        cnt    <= n_reg;
                        done_o <= 1'b0;
                        err_o  <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt <= N_W'(1)) begin
                        result <= acc;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else if (prod[2*DATA_W-1:DATA_W] != '0) begin
                        result <= (SATURATE != 0) ? '1 : '0;
                        err_o  <= 1'b1;
                        state  <= ERR;
                    end else begin
                        acc <= prod[DATA_W-1:0];
                        cnt <= cnt - N_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (a)
            2'd0: rd = {{(DATA_W-N_W){1'b0}}, n_reg};
            2'd1: rd = {{(DATA_W-1){1'b0}}, busy};
            2'd2: rd = {{(DATA_W-2){1'b0}}, err_o, done_o};
            2'd3: rd = result;
            default: rd = '0;
        endcase
    end
endmodule
